// File: rtl/psum_requant_pack.sv
// psum_requant_pack: requantize signed psums to unsigned lanes and pack them into words; REQUANT_ROUND_EN adds round-half-up before the shift
module psum_requant_pack #(
  parameter int psum_bw = 16,
  parameter int act_bw = 4,
  parameter int pack = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [psum_bw-1:0]      psum_in,
  input  logic [3:0]              shift,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [pack*act_bw-1:0]  out_data,
  output logic [15:0]             word_cnt
);
  localparam int lw = pack > 1 ? $clog2(pack) : 1;
  localparam logic [lw-1:0] last = lw'(pack - 1);
  localparam logic [psum_bw:0] amax = (psum_bw + 1)'((1 << act_bw) - 1);
  logic [lw-1:0]            lane;
  logic [3:0]               shift_q, sh;
  logic                     flush_pending;
  logic [pack*act_bw-1:0]   acc, word_next;
  logic [psum_bw:0]         ext, shifted;
  logic [act_bw-1:0]        q;
  logic                     accept, out_free, full_load, flush_done, flush_load, load;
  // requantize the incoming psum with the word's shift and merge it into the current lane
  always_comb begin
    sh = lane == '0 ? shift : shift_q;
    ext = {1'b0, psum_in};
`ifdef REQUANT_ROUND_EN
    ext = ext + (sh == 4'd0 ? '0 : ((psum_bw + 1)'(1) << (sh - 4'd1)));
`endif
    shifted = ext >> sh;
    q = psum_in[psum_bw-1] ? '0 : (shifted > amax ? '1 : shifted[act_bw-1:0]);
    word_next = acc;
    word_next[lane*act_bw +: act_bw] = q;
  end
  // handshake and load decisions; a full word may only complete when the output register is free
  always_comb begin
    out_free = !out_valid || out_ready;
    in_ready = !(flush_pending || (lane == last && !out_free));
    accept = in_valid && in_ready;
    full_load = accept && lane == last;
    flush_done = flush_pending && (out_free || lane == '0);
    flush_load = flush_done && lane != '0;
    load = full_load || flush_load;
  end
  // lane packing, output register, word counter and pending flush
  always_ff @(posedge clk) begin
    if (reset) begin
      lane <= '0;
      shift_q <= '0;
      acc <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      word_cnt <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (accept && lane == '0) shift_q <= shift;
      lane <= load ? '0 : accept ? lane + 1'b1 : lane;
      acc <= load ? '0 : accept ? word_next : acc;
      if (load) begin
        out_data <= full_load ? word_next : acc;
        word_cnt <= word_cnt + 16'd1;
      end
      out_valid <= load || (out_valid && !out_ready);
      flush_pending <= flush || (flush_pending && !flush_done);
    end
  end
endmodule

// File: tb/tb_psum_requant_pack.sv
// tb_psum_requant_pack: directed self-checking bench for psum_requant_pack
module tb_psum_requant_pack;
  logic        clk = 0, reset = 1, in_valid = 0, in_ready, flush = 0;
  logic        out_valid, out_ready = 1;
  logic [15:0] psum_in = 0, word_cnt;
  logic [3:0]  shift = 0;
  logic [31:0] out_data;
  int checks = 0, failures = 0;

  psum_requant_pack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .psum_in(psum_in), .shift(shift), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input int v, input int s, input logic f);
    int n;
    @(negedge clk);
    in_valid = 1; psum_in = 16'(v); shift = 4'(s); flush = f;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; in_valid = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_word_cnt", {16'd0, word_cnt}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    for (int i = 0; i < 7; i++) send(i, 0, 0);
    chk("seq_latency_valid", {31'd0, out_valid}, 0);
    send(7, 0, 0);
    chk("seq_valid", {31'd0, out_valid}, 1);
    chk("seq_data", out_data, 32'h76543210);
    chk("seq_cnt", {16'd0, word_cnt}, 1);
    @(posedge clk); #1;
    chk("seq_consumed", {31'd0, out_valid}, 0);

    send(300, 4, 0);
    send(-5, 0, 0);
    for (int i = 0; i < 6; i++) send(16, 0, 0);
    chk("sat_data", out_data, 32'h1111110F);
    chk("sat_cnt", {16'd0, word_cnt}, 2);

    do_reset();
    out_ready = 0;
    for (int i = 0; i < 15; i++) send(2, 0, 0);
    @(negedge clk);
    chk("bp_held_valid", {31'd0, out_valid}, 1);
    chk("bp_held_data", out_data, 32'h22222222);
    chk("bp_in_ready_low", {31'd0, in_ready}, 0);
    chk("bp_cnt1", {16'd0, word_cnt}, 1);
    out_ready = 1;
    send(2, 0, 0);
    chk("bp_word2_valid", {31'd0, out_valid}, 1);
    chk("bp_word2_data", out_data, 32'h22222222);
    chk("bp_cnt2", {16'd0, word_cnt}, 2);
    @(posedge clk); #1;
    chk("bp_drained", {31'd0, out_valid}, 0);

    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0);
    @(negedge clk); flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_in_ready_low", {31'd0, in_ready}, 0);
    chk("flush_not_yet", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    chk("flush_valid", {31'd0, out_valid}, 1);
    chk("flush_data", out_data, 32'h00000321);
    chk("flush_cnt", {16'd0, word_cnt}, 3);
    for (int i = 0; i < 8; i++) send(9, 0, 0);
    chk("after_flush_data", out_data, 32'h99999999);
    chk("after_flush_cnt", {16'd0, word_cnt}, 4);

    @(negedge clk); flush = 1;
    @(posedge clk); #1 flush = 0;
    repeat (3) @(posedge clk); #1;
    chk("idle_flush_valid", {31'd0, out_valid}, 0);
    chk("idle_flush_cnt", {16'd0, word_cnt}, 4);
    chk("idle_flush_ready", {31'd0, in_ready}, 1);

    for (int i = 0; i < 7; i++) send(3, 0, 0);
    send(3, 0, 1);
    chk("coflush_data", out_data, 32'h33333333);
    chk("coflush_cnt", {16'd0, word_cnt}, 5);
    repeat (3) @(posedge clk); #1;
    chk("coflush_no_extra_cnt", {16'd0, word_cnt}, 5);
    chk("coflush_no_extra_valid", {31'd0, out_valid}, 0);

    for (int i = 0; i < 5; i++) send(4, 0, 0);
    do_reset();
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_cnt", {16'd0, word_cnt}, 0);
    chk("midrst_ready", {31'd0, in_ready}, 1);
    for (int i = 0; i < 8; i++) send(7, 0, 0);
    chk("midrst_data", out_data, 32'h77777777);
    chk("midrst_cnt1", {16'd0, word_cnt}, 1);

    send(24, 4, 0);
    send(255, 0, 0);
    send(256, 0, 0);
    send(32767, 0, 0);
    send(-32768, 0, 0);
    send(8, 0, 0);
    send(7, 0, 0);
    send(0, 0, 0);
`ifdef REQUANT_ROUND_EN
    chk("round_data", out_data, 32'h0010FFF2);
`else
    chk("trunc_data", out_data, 32'h0000FFF1);
`endif
    chk("round_cnt", {16'd0, word_cnt}, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/psum_requant_pack.md
PSUM_REQUANT_PACK -- requirements
Module: psum_requant_pack

Interface
REQ-001 Parameter psum_bw, default 16, width of the signed accumulator result from the SFU stage.
REQ-002 Parameter act_bw, default 4, width of each unsigned requantized activation lane.
REQ-003 Parameter pack, default 8, number of lanes per output word; out_data width = pack*act_bw (32 at defaults).
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  psum_in carries a value to accept.
REQ-007 in_ready  output  1  block can accept psum_in this cycle.
REQ-008 psum_in  input  psum_bw  signed accumulator value (SFU psum_out).
REQ-009 shift  input  4  right-shift amount, 0..15.
REQ-010 flush  input  1  single-cycle pulse; emit partial word.
REQ-011 out_valid  output  1  out_data holds a complete packed word.
REQ-012 out_ready  input  1  consumer takes out_data this cycle.
REQ-013 out_data  output  pack*act_bw  packed activation word.
REQ-014 word_cnt  output  16  count of words emitted, wraps 0xFFFF -> 0.

Function
REQ-015 An input is accepted on a cycle with in_valid && in_ready; an output is consumed on a cycle with out_valid && out_ready.
REQ-016 Requant per accepted value: negative psum -> 0; else arithmetic right shift by shift; result > 2^act_bw-1 saturates to 2^act_bw-1.
REQ-017 shift is captured on the lane-0 accept of each word and used for all lanes of that word.
REQ-018 Lane counter 0..pack-1; the k-th accepted value of a word lands in out bits [k*act_bw +: act_bw]; counter increments per accept and wraps to 0 after lane pack-1.
REQ-019 On the lane pack-1 accept, the full word (including that lane) loads the output register; out_valid is high the next cycle (1-cycle latency).
REQ-020 out_data and out_valid hold stable while out_valid && !out_ready.
REQ-021 in_ready = 0 when (lane == pack-1 && out_valid && !out_ready) or flush_pending = 1; otherwise 1; lanes 0..pack-2 keep filling while the output register is held.
REQ-022 Output load and consume in the same cycle: new word loads, out_valid stays 1.
REQ-023 flush sets flush_pending; with flush_pending set and (out_valid == 0 or out_ready), if lane > 0 the partial word, zero-padded, loads the output register, lane resets to 0; flush_pending clears in that cycle.
REQ-024 flush with lane == 0 and no accept that cycle: no word emitted, flush_pending clears next cycle.
REQ-025 flush coincident with an accept: the accepted value is included before the flush; if it completes the word, that full word is emitted and no extra empty word follows.
REQ-026 word_cnt increments by 1 on each output register load (full or partial).

Reset
REQ-027 On reset: out_valid = 0, out_data = 0, word_cnt = 0, lane = 0, flush_pending = 0, captured shift = 0; in_ready = 1 the cycle after reset deasserts.
REQ-028 Reset mid-word discards partially packed lanes and any held output word; no word emits on reset release.

Configuration
REQ-029 Macro REQUANT_ROUND_EN: when defined, add 2^(shift-1) (for shift > 0) to non-negative psum before the shift, using psum_bw+1 bit arithmetic so no overflow occurs, then saturate.
REQ-030 Without REQUANT_ROUND_EN, the shift truncates (floor); no rounding logic is present.

Verification
REQ-031 shift=0, psum 0..7 back-to-back, out_ready=1 -> out_data=0x76543210, out_valid one cycle after 8th accept, word_cnt=1.
REQ-032 shift=4, psum 300 then -5 then six 16s, out_ready=1 -> lanes 0xF, 0x0, 0x1 x6; out_data=0x111111 0F as 0x1111110F.
REQ-033 out_ready=0, stream 16 values of 2 at shift=0 -> first word 0x22222222 held; in_ready drops at second word lane 7; raise out_ready -> two words in order, word_cnt=2.
REQ-034 Values 1,2,3 at shift=0 then flush pulse -> out_data=0x00000321, word_cnt increments, next word starts at lane 0.
REQ-035 Reset after 5 accepts -> out_valid=0, word_cnt=0; next 8 values of 7 -> 0x77777777.
REQ-036 psum 24, shift=4 -> lane value 2 with REQUANT_ROUND_EN, 1 without.
